fetch_decode_queue: RTL and testbench

//   Parametrised elastic pipeline register between fetch and decode; generalises decoder_state.

---
 rtl/fetch_decode_queue_pkg.sv | 14 +
 rtl/fetch_decode_queue_if.sv | 31 +++
 rtl/fetch_decode_queue_circ_ptr.sv | 24 ++
 rtl/fetch_decode_queue.sv | 91 +++++++++
 tb/tb_fetch_decode_queue.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch/decode queue.
package fetch_decode_queue_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0: presented to decode whenever the queue is empty
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fd_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle for fetch_decode_queue.
// Signal prefixes are from the queue's point of view: i_* into the queue, o_* out of it.
interface fetch_decode_queue_if #(
  parameter int unsigned Depth = 2
);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic                                  i_flush;
  logic                                  i_valid;
  logic                                  o_ready;
  logic [fetch_decode_queue_pkg::XLEN-1:0] i_pc;
  logic [fetch_decode_queue_pkg::XLEN-1:0] i_instruction;
  logic                                  o_valid;
  logic                                  i_ready;
  logic [fetch_decode_queue_pkg::XLEN-1:0] o_pc;
  logic [fetch_decode_queue_pkg::XLEN-1:0] o_instruction;
  logic [CntW-1:0]                       o_count;

  // Queue side
  modport slave (
    input  i_flush, i_valid, i_pc, i_instruction, i_ready,
    output o_ready, o_valid, o_pc, o_instruction, o_count
  );

  // Fetch/decode (environment) side
  modport master (
    output i_flush, i_valid, i_pc, i_instruction, i_ready,
    input  o_ready, o_valid, o_pc, o_instruction, o_count
  );

endinterface

// File: rtl/fetch_decode_queue_circ_ptr.sv
// Wrap-around pointer increment; Depth need not be a power of two.
module fetch_decode_queue_circ_ptr #(
  parameter int unsigned Depth = 2
) (
  input  logic [$clog2(Depth)-1:0] ptr,
  input  logic                     inc,
  output logic [$clog2(Depth)-1:0] ptr_next
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Advance by one, explicit wrap at Depth-1
  always_comb begin
    ptr_next = ptr;
    if (inc) begin
      if (ptr == PtrW'(Depth - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = ptr + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Elastic circular queue of {pc, instruction} pairs between fetch and decode.
// Shows a NOP bubble (pc=0) to decode whenever empty; flush drops all entries.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input logic                  i_clk,
  input logic                  i_reset,
  fetch_decode_queue_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fd_entry_t           mem [Depth];
  logic [PtrW-1:0]     rd_q, wr_q, rd_next, wr_next;
  logic [CntW-1:0]     count_q, count_d;
  logic                ready, valid, push, pop;
  fd_entry_t           head;

  // Ready depends only on stored state, so there is no path from decode's i_ready
  assign ready = (count_q < CntW'(Depth));
  assign valid = (count_q != '0);
  assign push  = bus.i_valid & ready;
  assign pop   = valid & bus.i_ready;
  assign head  = mem[rd_q];

  fetch_decode_queue_circ_ptr #(.Depth(Depth)) u_rd_ptr (
    .ptr      (rd_q),
    .inc      (pop),
    .ptr_next (rd_next)
  );

  fetch_decode_queue_circ_ptr #(.Depth(Depth)) u_wr_ptr (
    .ptr      (wr_q),
    .inc      (push),
    .ptr_next (wr_next)
  );

  // Occupancy next-state; push+pop together leaves count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; reset beats flush, flush beats push/pop
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_next;
      wr_q    <= wr_next;
      count_q <= count_d;
    end
  end

  // Storage is not reset; a flushed push is simply never written
  always_ff @(posedge i_clk) begin
    if (push && !bus.i_flush && !i_reset) begin
      mem[wr_q] <= '{pc: bus.i_pc, instruction: bus.i_instruction};
    end
  end

  // Outputs mask the head slot when empty so stale data never leaks
  always_comb begin
    bus.o_ready       = ready;
    bus.o_valid       = valid;
    bus.o_count       = count_q;
    bus.o_pc          = '0;
    bus.o_instruction = NOP_INSTR;
    if (valid) begin
      bus.o_pc          = head.pc;
      bus.o_instruction = head.instruction;
    end
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge i_clk) count_q <= CntW'(Depth));

  a_full_push_ignored : assert property (@(posedge i_clk) disable iff (i_reset || bus.i_flush)
      (bus.i_valid && !ready && !pop) |=> (count_q == $past(count_q)) && (wr_q == $past(wr_q)));
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue at Depth=2 and Depth=5.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  fetch_decode_queue_if #(.Depth(2)) bus2 ();
  fetch_decode_queue_if #(.Depth(5)) bus5 ();

  fetch_decode_queue #(.Depth(2)) dut2 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus2)
  );

  fetch_decode_queue #(.Depth(5)) dut5 (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc, ins;
    logic [31:0] q[$];
    int          pushed, popped;
    logic        do_push, do_pop;

    bus2.i_flush = 0; bus2.i_valid = 0; bus2.i_ready = 0; bus2.i_pc = 0; bus2.i_instruction = 0;
    bus5.i_flush = 0; bus5.i_valid = 0; bus5.i_ready = 0; bus5.i_pc = 0; bus5.i_instruction = 0;

    // 1. Reset for two edges
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_valid", 32'(bus2.o_valid), 32'd0);
    check("rst2_ready", 32'(bus2.o_ready), 32'd1);
    check("rst2_count", 32'(bus2.o_count), 32'd0);
    check("rst2_instr", bus2.o_instruction, 32'h0000_0013);
    check("rst2_pc", bus2.o_pc, 32'd0);
    check("rst5_count", 32'(bus5.o_count), 32'd0);
    check("rst5_instr", bus5.o_instruction, 32'h0000_0013);

    // 2. Single push, decode stalled
    bus2.i_valid = 1; bus2.i_pc = 32'h100; bus2.i_instruction = 32'hDEAD_BEEF;
    step();
    check("push1_valid", 32'(bus2.o_valid), 32'd1);
    check("push1_pc", bus2.o_pc, 32'h100);
    check("push1_instr", bus2.o_instruction, 32'hDEAD_BEEF);
    check("push1_count", 32'(bus2.o_count), 32'd1);
    check("push1_ready", 32'(bus2.o_ready), 32'd1);

    // 3. Fill, offer while full, then drain in order
    bus2.i_pc = 32'h104; bus2.i_instruction = 32'h1111_0104;
    step();
    check("full_count", 32'(bus2.o_count), 32'd2);
    check("full_ready", 32'(bus2.o_ready), 32'd0);
    check("full_head", bus2.o_pc, 32'h100);
    bus2.i_pc = 32'h108; bus2.i_instruction = 32'h1111_0108;
    step();
    check("offer_count", 32'(bus2.o_count), 32'd2);
    check("offer_head", bus2.o_pc, 32'h100);
    bus2.i_valid = 0; bus2.i_ready = 1;
    step();
    check("drain1_pc", bus2.o_pc, 32'h104);
    check("drain1_instr", bus2.o_instruction, 32'h1111_0104);
    check("drain1_count", 32'(bus2.o_count), 32'd1);
    step();
    check("drain2_count", 32'(bus2.o_count), 32'd0);
    check("drain2_valid", 32'(bus2.o_valid), 32'd0);
    check("drain2_instr", bus2.o_instruction, NOP_INSTR);
    check("drain2_pc", bus2.o_pc, 32'd0);
    step();
    check("empty_pop_count", 32'(bus2.o_count), 32'd0);

    // 4. Streaming with both sides always ready
    for (int i = 0; i < 100; i++) begin
      pc  = $urandom;
      ins = $urandom;
      bus2.i_valid = 1; bus2.i_ready = 1; bus2.i_pc = pc; bus2.i_instruction = ins;
      step();
      check("stream_pc", bus2.o_pc, pc);
      check("stream_instr", bus2.o_instruction, ins);
      check("stream_count", 32'(bus2.o_count), 32'd1);
    end
    bus2.i_valid = 0;
    step();
    check("stream_drain_count", 32'(bus2.o_count), 32'd0);
    bus2.i_ready = 0;

    // 5. Depth=5 flush with a same-cycle push
    for (int i = 0; i < 3; i++) begin
      bus5.i_valid = 1; bus5.i_pc = 32'h300 + 32'(4 * i); bus5.i_instruction = 32'hA000_0000 + 32'(i);
      step();
      check("fill5_count", 32'(bus5.o_count), 32'(i + 1));
    end
    check("fill5_head", bus5.o_pc, 32'h300);
    bus5.i_flush = 1; bus5.i_pc = 32'h200; bus5.i_instruction = 32'hBAD0_0200;
    step();
    check("flush_count", 32'(bus5.o_count), 32'd0);
    check("flush_valid", 32'(bus5.o_valid), 32'd0);
    check("flush_instr", bus5.o_instruction, NOP_INSTR);
    check("flush_pc", bus5.o_pc, 32'd0);
    step();
    check("flush2_count", 32'(bus5.o_count), 32'd0);
    bus5.i_flush = 0; bus5.i_pc = 32'h20C; bus5.i_instruction = 32'hC000_020C;
    step();
    check("postflush_pc", bus5.o_pc, 32'h20C);
    check("postflush_count", 32'(bus5.o_count), 32'd1);
    bus5.i_valid = 0; bus5.i_ready = 1;
    step();
    check("postflush_drain", 32'(bus5.o_count), 32'd0);

    // 6. Depth=5 wrap with random decode stalls, checked against a queue model
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 12; cyc++) begin
      bus5.i_valid = (pushed < 12);
      bus5.i_pc = 32'h400 + 32'(4 * pushed);
      bus5.i_instruction = ~bus5.i_pc;
      bus5.i_ready = ($urandom_range(0, 2) == 0);
      do_push = bus5.i_valid && (q.size() < 5);
      do_pop  = (q.size() != 0) && bus5.i_ready;
      step();
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) begin
        q.push_back(bus5.i_pc);
        pushed++;
      end
      check("wrap_count", 32'(bus5.o_count), 32'(q.size()));
      check("wrap_ready", 32'(bus5.o_ready), 32'(q.size() < 5));
      if (q.size() != 0) begin
        check("wrap_pc", bus5.o_pc, q[0]);
        check("wrap_instr", bus5.o_instruction, ~q[0]);
      end else begin
        check("wrap_nop", bus5.o_instruction, NOP_INSTR);
      end
    end
    check("wrap_popped", 32'(popped), 32'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
